// File: rtl/fifo_frame_reader_if.sv
// fifo_frame_reader_if: FIFO read handshake plus framed output stream.
interface fifo_frame_reader_if #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_SIZE  = 1024
);
  logic [DATA_WIDTH-1:0]      fifo_data;
  logic                       fifo_rdy;
  logic [$clog2(FIFO_SIZE):0] fifo_size;
  logic                       fifo_pop;
  logic                       fifo_flush;
  logic [DATA_WIDTH-1:0]      m_data;
  logic                       m_vld;
  logic                       m_last;
  logic                       m_rdy;
  modport master(
    input  fifo_data, fifo_rdy, fifo_size, m_rdy,
    output fifo_pop, fifo_flush, m_data, m_vld, m_last
  );
  modport slave(
    output fifo_data, fifo_rdy, fifo_size, m_rdy,
    input  fifo_pop, fifo_flush, m_data, m_vld, m_last
  );
endinterface

// File: rtl/fifo_frame_reader.sv
// fifo_frame_reader: drains a sample FIFO into header/payload/XOR-checksum frames.
module fifo_frame_reader #(
  parameter int          DATA_WIDTH = 32,
  parameter int          FIFO_SIZE  = 1024,
  parameter int          FRAME_LEN  = 256,
  parameter logic [15:0] HDR_MAGIC  = 16'hA55A
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 enable,
  input  logic                 abort,
  fifo_frame_reader_if.master  bus,
  output logic                 busy,
  output logic [15:0]          frame_seq,
  output logic [31:0]          frames_sent
);
  localparam int SW = $clog2(FIFO_SIZE) + 1;
  localparam int CW = $clog2(FRAME_LEN + 1);
  typedef enum logic [1:0] {IDLE, WAIT, PLD, CHK} state_t;
  state_t                state, nxt;
  logic [DATA_WIDTH-1:0] chk;
  logic [CW-1:0]         pld_cnt;
  logic                  free, fill, last_pld, ld_hdr, ld_pld, ld_chk, ld;
  assign free     = ~bus.m_vld | bus.m_rdy;
  assign fill     = bus.fifo_size >= SW'(FRAME_LEN);
  assign last_pld = pld_cnt == CW'(FRAME_LEN - 1);
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) state <= IDLE;
    else       state <= nxt;
  always_comb begin
    nxt = abort            ? IDLE :
          state == IDLE    ? (enable ? WAIT : IDLE) :
          state == WAIT    ? (~enable ? IDLE : (fill & free ? PLD : WAIT)) :
          state == PLD     ? (ld_pld & last_pld ? CHK : PLD) :
          free             ? (enable ? WAIT : IDLE) : CHK;
  end
  // Loads are gated by abort so an abort cycle never pops or overwrites the slot.
  always_comb begin
    ld_hdr       = ~abort & (state == WAIT) & enable & fill & free;
    ld_pld       = ~abort & (state == PLD) & free & bus.fifo_rdy;
    ld_chk       = ~abort & (state == CHK) & free;
    ld           = ld_hdr | ld_pld | ld_chk;
    bus.fifo_pop = ld_pld;
    busy         = state != IDLE;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bus.m_data     <= '0;
      bus.m_vld      <= 1'b0;
      bus.m_last     <= 1'b0;
      bus.fifo_flush <= 1'b0;
      chk            <= '0;
      pld_cnt        <= '0;
      frame_seq      <= '0;
      frames_sent    <= '0;
    end else begin
      bus.fifo_flush <= abort;
      if (abort) begin
        bus.m_vld  <= 1'b0;
        bus.m_last <= 1'b0;
        chk        <= '0;
      end else begin
        if (ld) begin
          bus.m_vld  <= 1'b1;
          bus.m_last <= ld_chk;
          bus.m_data <= ld_hdr ? DATA_WIDTH'({HDR_MAGIC, frame_seq}) : ld_pld ? bus.fifo_data : chk;
        end else if (bus.m_rdy) bus.m_vld <= 1'b0;
        if (ld_hdr) begin
          chk     <= '0;
          pld_cnt <= '0;
        end
        if (ld_pld) begin
          chk     <= chk ^ bus.fifo_data;
          pld_cnt <= pld_cnt + CW'(1);
        end
        if (ld_chk) begin
          frame_seq   <= frame_seq + 16'd1;
          frames_sent <= frames_sent + 32'd1;
        end
      end
    end
  end
endmodule

// File: doc/fifo_frame_reader.md
# fifo_frame_reader

Drain-side companion to the sample FIFO in the phase-noise capture path. Pops samples through the FIFO's read handshake and emits fixed-length frames to the host streaming interface. Each frame is a header word, FRAME_LEN payload samples, and an XOR checksum word. Frame boundaries stay aligned to FIFO contents because a frame starts only when a whole frame is already buffered.

## Interface
- DATA_WIDTH, 32: sample/word width; must be ≥ 32.
- FIFO_SIZE, 1024: depth of the attached FIFO; sets the fifo_size width to $clog2(FIFO_SIZE)+1.
- FRAME_LEN, 256: payload words per frame; 1 ≤ FRAME_LEN ≤ FIFO_SIZE.
- HDR_MAGIC, 16'hA55A: header tag.

Ports:
- clk  in  1  single clock, rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- enable  in  1  level; permits starting new frames.
- abort  in  1  synchronous; kills the current frame.
- fifo_data  in  DATA_WIDTH  FIFO head word; combinational from the FIFO.
- fifo_rdy  in  1  FIFO non-empty.
- fifo_size  in  $clog2(FIFO_SIZE)+1  FIFO occupancy.
- fifo_pop  out  1  pop strobe to the FIFO; combinational.
- fifo_flush  out  1  registered 1-cycle flush pulse to the FIFO.
- m_data  out  DATA_WIDTH  stream data; registered.
- m_vld  out  1  stream valid; registered.
- m_last  out  1  marks the checksum word; registered.
- m_rdy  in  1  downstream ready.
- busy  out  1  state ≠ IDLE.
- frame_seq  out  16  sequence number of the next frame's header.
- frames_sent  out  32  count of completed frames.

## Operation
- Output register slot is free when ~m_vld | m_rdy. It is loaded only when free. When loaded, m_vld is set; otherwise m_vld clears on m_rdy.
- States:
  - IDLE: if enable & ~abort, go to WAIT.
  - WAIT: if fifo_size ≥ FRAME_LEN and the slot is free:
    - load header {HDR_MAGIC, frame_seq}, zero-extended to DATA_WIDTH;
    - clear the checksum and pld_cnt;
    - go to PLD.
  - WAIT with ~enable: go to IDLE.
  - PLD: when the slot is free and fifo_rdy:
    - fifo_pop = 1 and load fifo_data;
    - checksum ^= fifo_data;
    - pld_cnt++.
    - On the pop with pld_cnt == FRAME_LEN-1, go to CHK.
  - PLD with ~fifo_rdy: stall; no pop; m_vld drops once the last word is taken.
  - CHK: when the slot is free:
    - load the checksum with m_last = 1;
    - frame_seq++ (wraps at 0xFFFF → 0);
    - frames_sent++ (wraps);
    - go to WAIT if enable, else IDLE.
- fifo_pop is asserted only in PLD under the condition above. It is never asserted when fifo_rdy = 0, so FIFO underrun is impossible.
- enable deasserted mid-frame: the frame completes normally, then the block goes to IDLE.
- abort (any state):
  - next cycle state = IDLE; m_vld, m_last and the checksum clear;
  - no pop in the abort cycle;
  - frame_seq and frames_sent are unchanged;
  - fifo_flush pulses high for exactly the cycle after abort.
  - abort has priority over enable and over all loads.
- pld_cnt width is $clog2(FRAME_LEN+1). The checksum is DATA_WIDTH-wide XOR of the payload only.

## Timing
- Reset (async assert) gives:
  - state IDLE;
  - m_data = 0, m_vld = 0, m_last = 0, fifo_flush = 0;
  - frame_seq = 0, frames_sent = 0;
  - fifo_pop = 0 and busy = 0 (derived from state).
- Start latency:
  - enable sampled in IDLE at cycle N gives WAIT at N+1.
  - If fill is satisfied at N+1, header is valid at N+2.
- Throughput with m_rdy held high: one word per cycle.
  - A frame takes FRAME_LEN+2 cycles.
  - Frames run back-to-back when the next frame is already buffered.
- m_data and m_last stay stable while m_vld & ~m_rdy.
- fifo_size is sampled only in WAIT. It lags one cycle after a pop, which is harmless because only this block pops.
- Reset asserted mid-frame: all outputs go to reset values immediately; the partial frame is dropped without flushing the FIFO.

## Test plan
- FRAME_LEN=4; preload 1,2,3,4; enable=1, m_rdy=1 → stream 0xA55A0000, 1, 2, 3, 4, 0x00000004. m_last only on the final word; frames_sent=1, frame_seq=1; 4 pops total.
- Same frame with m_rdy toggling 1,0,0,1,… → each word held stable while stalled; no pop while the slot is occupied; identical word sequence.
- Preload 3 words, FRAME_LEN=4 → stays in WAIT: m_vld=0, fifo_pop never high. Push a 4th word → the frame starts.
- Abort after 2 payload words accepted → next cycle m_vld=0, state IDLE, one-cycle fifo_flush pulse; frame_seq and frames_sent unchanged. The next frame's header still carries the old seq.
- Drop enable during PLD of frame 0 with 8 words buffered → frame 0 completes with m_last, then IDLE; frame 1 is not started and busy=0.
- Assert rstn=0 mid-PLD, asynchronously between clock edges → m_vld, m_last and m_data go to 0 before the next edge; counters are 0.
